mac_lane_array: RTL

Parametrised successor to the single 3-tap MAC datapath in the convolution top level. It computes LANES output channels in parallel. All lanes share one TAPS-wide activation vector; each lane has its own weight vector.
- Accumulation source per beat: zero, internal accumulator, or external partial sum from memory.
- Pipeline: 2-stage with valid/ready backpressure.
- Outputs: raw accumulators plus a rounded, shifted, optionally saturated IO-width result, with a sticky overflow flag per lane.
- Sits between the controller FSM / operand registers and the external partial-sum memory write port.

---
 rtl/mac_lane_array.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mac_lane_array.sv
// Multi-lane multiply-accumulate array: LANES output channels share one TAPS-wide
// activation vector, each with its own weights, behind a 2-stage valid/ready pipeline.
module mac_lane_array #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int TAPS        = 3,
    parameter int LANES       = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 20,
    parameter int SCALE_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             srst_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TAPS*A_WIDTH-1:0]          a_in,
    input  logic [LANES*TAPS*B_WIDTH-1:0]    b_in,
    input  logic [1:0]                       psum_sel,
    input  logic [LANES*ACC_WIDTH-1:0]       psum_in,
    input  logic                             last_in,
    input  logic [ADDR_WIDTH-1:0]            addr_in,
    input  logic [SCALE_WIDTH-1:0]           scale,
    input  logic                             sat_en,
    input  logic                             ovf_clr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*ACC_WIDTH-1:0]       acc_out,
    output logic [LANES*OUT_WIDTH-1:0]       q_out,
    output logic [ADDR_WIDTH-1:0]            addr_out,
    output logic [LANES-1:0]                 overflow
);

    localparam int PROD_W  = A_WIDTH + B_WIDTH;
    localparam int GUARD_W = ACC_WIDTH + $clog2(TAPS + 1);
    localparam logic signed [ACC_WIDTH:0] Q_MAX =
        (ACC_WIDTH+1)'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] Q_MIN = ~Q_MAX;

    logic                         advance;
    logic signed [A_WIDTH-1:0]    a_tap    [TAPS];
    logic signed [B_WIDTH-1:0]    b_tap    [LANES][TAPS];

    logic                         s1_valid;
    logic                         s1_last;
    logic [1:0]                   s1_sel;
    logic [ADDR_WIDTH-1:0]        s1_addr;
    logic signed [PROD_W-1:0]     s1_prod  [LANES][TAPS];
    logic signed [ACC_WIDTH-1:0]  s1_psum  [LANES];

    logic signed [ACC_WIDTH-1:0]  acc      [LANES];
    logic signed [GUARD_W-1:0]    full_sum [LANES];
    logic [LANES-1:0]             ovf_hit;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar t = 0; t < TAPS; t++) begin : g_a_unpack
        assign a_tap[t] = a_in[t*A_WIDTH +: A_WIDTH];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane_io
        for (genvar t = 0; t < TAPS; t++) begin : g_b_unpack
            assign b_tap[l][t] = b_in[(l*TAPS+t)*B_WIDTH +: B_WIDTH];
        end
        assign acc_out[l*ACC_WIDTH +: ACC_WIDTH] = acc[l];
    end

    // Stage 1: latch the full product matrix together with the beat's control fields.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sel   <= psum_sel;
            s1_last  <= last_in;
            s1_addr  <= addr_in;
            for (int l = 0; l < LANES; l++) begin
                s1_psum[l] <= psum_in[l*ACC_WIDTH +: ACC_WIDTH];
                for (int t = 0; t < TAPS; t++) begin
                    s1_prod[l][t] <= PROD_W'(a_tap[t]) * PROD_W'(b_tap[l][t]);
                end
            end
        end
    end

    // Guard bits keep the exact sum so overflow can be judged before the wrap to ACC_WIDTH.
    always_comb begin
        ovf_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            case (s1_sel)
                2'd1:    full_sum[l] = GUARD_W'(acc[l]);
                2'd2:    full_sum[l] = GUARD_W'(s1_psum[l]);
                default: full_sum[l] = '0;
            endcase
            for (int t = 0; t < TAPS; t++) begin
                full_sum[l] = full_sum[l] + GUARD_W'(s1_prod[l][t]);
            end
            ovf_hit[l] = (full_sum[l][GUARD_W-1:ACC_WIDTH-1] != '0) &&
                         (full_sum[l][GUARD_W-1:ACC_WIDTH-1] != '1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst_in) begin
            out_valid <= 1'b0;
            addr_out  <= '0;
            overflow  <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
            end
        end else begin
            if (advance) begin
                out_valid <= s1_valid && s1_last;
                if (s1_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        acc[l] <= full_sum[l][ACC_WIDTH-1:0];
                    end
                    if (s1_last) begin
                        addr_out <= s1_addr;
                    end
                end
            end
            // A fresh overflow in the same cycle beats a clear request.
            overflow <= ((advance && s1_valid) ? ovf_hit : '0) | (ovf_clr ? '0 : overflow);
        end
    end

    // Round-half-up then arithmetic shift; one extra bit absorbs the rounding carry.
    always_comb begin
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] r;
        logic signed [ACC_WIDTH:0] clamped;
        q_out   = '0;
        ext     = '0;
        rnd     = '0;
        r       = '0;
        clamped = '0;
        for (int l = 0; l < LANES; l++) begin
            ext = (ACC_WIDTH+1)'(acc[l]);
            rnd = (scale == '0) ? '0 : ((ACC_WIDTH+1)'(1) << (scale - SCALE_WIDTH'(1)));
            r   = (ext + rnd) >>> scale;
            if (r > Q_MAX) begin
                clamped = Q_MAX;
            end else if (r < Q_MIN) begin
                clamped = Q_MIN;
            end else begin
                clamped = r;
            end
            q_out[l*OUT_WIDTH +: OUT_WIDTH] = sat_en ? clamped[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
        end
    end

endmodule
